// File: rtl/reg_dc_pkg.sv
// Shared constants and types for the decode-stage register read/bypass slice.
// Holds default widths and the register-number width helper.
package reg_dc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREG   = 8;
  localparam int DEF_CNT_W  = 8;

  function automatic int reg_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int DEF_AW = reg_aw(DEF_NREG);

  typedef logic [DEF_AW-1:0] reg_num_t;

endpackage

// File: rtl/reg_dc_rdport.sv
// One combinational register read port: slice select, zero register,
// write-back bypass and a bypass-hit flag for the event counter.
module reg_dc_rdport
  import reg_dc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREG     = DEF_NREG,
  parameter int AW       = reg_aw(NREG),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic [AW-1:0]          n_reg,
  input  logic [NREG*DATA_W-1:0] reg_all,
  input  logic                   wb_en,
  input  logic [AW-1:0]          n_wb,
  input  logic [DATA_W-1:0]      wb_data,
  output logic [DATA_W-1:0]      data,
  output logic                   hit
);

  logic [DATA_W-1:0] sel;
  logic              is_zero;

  assign sel     = reg_all[int'(n_reg)*DATA_W +: DATA_W];
  assign is_zero = ZERO_REG && (n_reg == '0);
  // register 0 under ZERO_REG never counts as a bypass
  assign hit     = !is_zero && wb_en && (n_wb == n_reg);

  always_comb begin
    data = sel;
    unique case (1'b1)
      is_zero: data = '0;
      hit:     data = wb_data;
      default: data = sel;
    endcase
  end

endmodule

// File: rtl/reg_dc_bypass.sv
// Decode stage: dual register read with write-back bypass into a one-entry
// valid/ready output stage, held-operand coherence and bypass counter.
module reg_dc_bypass
  import reg_dc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREG     = DEF_NREG,
  parameter bit ZERO_REG = 1'b0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                       CLK_DC,
  input  logic                       RESET_N,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [$clog2(NREG)-1:0]    N_REG_A_IN,
  input  logic [$clog2(NREG)-1:0]    N_REG_B_IN,
  input  logic [NREG*DATA_W-1:0]     REG_ALL,
  input  logic                       WB_EN,
  input  logic [$clog2(NREG)-1:0]    N_WB,
  input  logic [DATA_W-1:0]          WB_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [$clog2(NREG)-1:0]    N_REG_A_OUT,
  output logic [$clog2(NREG)-1:0]    N_REG_B_OUT,
  output logic [DATA_W-1:0]          REG_A_OUT,
  output logic [DATA_W-1:0]          REG_B_OUT,
  output logic [CNT_W-1:0]           BYPASS_CNT
);

  localparam int AW = reg_aw(NREG);

  logic              out_valid;
  logic              load;
  logic              hold;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              wb_ok;
  logic              upd_a;
  logic              upd_b;
  logic [CNT_W:0]    cnt_sum;

  reg_dc_rdport #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_rd_a (
    .n_reg   (N_REG_A_IN),
    .reg_all (REG_ALL),
    .wb_en   (WB_EN),
    .n_wb    (N_WB),
    .wb_data (WB_DATA),
    .data    (rd_a),
    .hit     (hit_a)
  );

  reg_dc_rdport #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_rd_b (
    .n_reg   (N_REG_B_IN),
    .reg_all (REG_ALL),
    .wb_en   (WB_EN),
    .n_wb    (N_WB),
    .wb_data (WB_DATA),
    .data    (rd_b),
    .hit     (hit_b)
  );

  assign OUT_VALID = out_valid;
  assign IN_READY  = !out_valid || OUT_READY;
  assign load      = IN_VALID && IN_READY;
  assign hold      = out_valid && !OUT_READY;

  // held operands track later write-backs so execute never sees stale data
  assign wb_ok = WB_EN && !(ZERO_REG && (N_WB == '0));
  assign upd_a = hold && wb_ok && (N_WB == N_REG_A_OUT);
  assign upd_b = hold && wb_ok && (N_WB == N_REG_B_OUT);

  // carry out of the sum means the counter would pass all-ones
  assign cnt_sum = (CNT_W+1)'(BYPASS_CNT)
                 + (CNT_W+1)'(hit_a)
                 + (CNT_W+1)'(hit_b);

  always_ff @(posedge CLK_DC or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid   <= 1'b0;
      N_REG_A_OUT <= '0;
      N_REG_B_OUT <= '0;
      REG_A_OUT   <= '0;
      REG_B_OUT   <= '0;
      BYPASS_CNT  <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      N_REG_A_OUT <= N_REG_A_IN;
      N_REG_B_OUT <= N_REG_B_IN;
      REG_A_OUT   <= rd_a;
      REG_B_OUT   <= rd_b;
      BYPASS_CNT  <= cnt_sum[CNT_W] ? '1
                                    : cnt_sum[CNT_W-1:0];
    end else begin
      if (OUT_READY) begin
        out_valid <= 1'b0;
      end
      if (upd_a) begin
        REG_A_OUT <= WB_DATA;
      end
      if (upd_b) begin
        REG_B_OUT <= WB_DATA;
      end
    end
  end

endmodule
